pb_step_conditioner: RTL and testbench
======================================

Name: pb_step_conditioner

Overview:
- Upstream input stage for the pushbutton-driven state-machine labs.
- Takes the raw `pb` bus and synchronizes and debounces every bit.
- Produces one-cycle press/release strobes and a priority-encoded key index.
- Drives the two control pulses the downstream state register consumes: `step`, which advances state (with hold-to-auto-repeat), and `load`, which forces the preset state.
- The downstream stage therefore runs on `hz100` with clean enables instead of being clocked by raw buttons.

Parameters:
- `NBTN`, 21: width of the pushbutton bus.
- `DEB_TICKS`, 3: consecutive clocks a synchronized level must differ from the debounced level before the debounced level flips; legal range 1..15.
- `REPEAT_DELAY`, 50: clocks from the step press to the first auto-repeat step; must be ≥ 2.
- `REPEAT_PERIOD`, 10: clocks between subsequent auto-repeat steps; must be ≥ 1.
- `STEP_IDX`, 0: `pb` bit used as the step button.
- `LOAD_IDX`, 1: `pb` bit used as the load button; must differ from `STEP_IDX`.

Ports:
- `hz100`, input, 1: system clock, 100 Hz.
- `reset`, input, 1: asynchronous, active-low reset.
- `pb`, input, `NBTN`: raw pushbuttons, asynchronous, active-high.
- `db`, output, `NBTN`: debounced button levels.
- `press`, output, `NBTN`: one-cycle strobe on each debounced rising edge.
- `release`, output, `NBTN`: one-cycle strobe on each debounced falling edge.
- `key_valid`, output, 1: any debounced button is high.
- `key_idx`, output, 5: index of the lowest-numbered high `db` bit; 0 when `key_valid` = 0.
- `step`, output, 1: one-cycle advance enable for the downstream state register.
- `load`, output, 1: one-cycle preset enable for the downstream state register.

Behaviour:
- Clocking and reset:
  - Single clock `hz100`, rising edge. Reset is asynchronous and active-low.
  - While `reset` = 0, all flops clear: sync stages, `db`, delayed copy of `db`, debounce counters, repeat counter, FSM state.
  - Resulting outputs during reset: `db`, `press`, `release`, `step`, `load`, `key_valid` all 0; `key_idx` = 0; FSM in IDLE.
- Synchronizer:
  - Two flops per bit, no logic between them.
- Debounce, per bit, with a counter of 4 bits:
  - If sync output equals `db`: counter ← 0.
  - Otherwise counter increments. On the edge where it would reach `DEB_TICKS`, `db` flips and the counter ← 0.
  - A raw level first sampled at edge E0 and held appears on `db` after edge E0+1+`DEB_TICKS`.
  - A pulse shorter than `DEB_TICKS` synchronized cycles never changes `db`.
- Strobes (combinational from `db` and the registered `db_d`):
  - `press` = `db` & ~`db_d`.
  - `release` = ~`db` & `db_d`.
  - Each is high for exactly one cycle, coinciding with the first cycle of the new `db` level.
- Encoder:
  - `key_valid` = OR of `db`.
  - `key_idx` = lowest set index of `db`.
  - Both are combinational from `db`.
- Load:
  - `load` = `press[LOAD_IDX]`.
- Step FSM, states IDLE, WAIT, REPEAT, with repeat counter `rcnt` of 16 bits:
  - IDLE: on `press[STEP_IDX]` with `db[LOAD_IDX]` = 0, assert `step` that cycle; `rcnt` ← 1; go to WAIT.
  - WAIT: if `db[STEP_IDX]` = 0, go to IDLE. Otherwise `rcnt` increments. When `rcnt` = `REPEAT_DELAY`, assert `step`, `rcnt` ← 1, and go to REPEAT.
  - REPEAT: if `db[STEP_IDX]` = 0, go to IDLE. Otherwise `rcnt` increments. When `rcnt` = `REPEAT_PERIOD`, assert `step` and set `rcnt` ← 1.
  - `step` timing for a press in cycle P: high in cycles P, P+`REPEAT_DELAY`, and P+`REPEAT_DELAY`+k·`REPEAT_PERIOD` for k ≥ 1, for as long as the button is held.
  - Load priority: whenever `db[LOAD_IDX]` = 1, `step` is forced to 0 and the FSM goes to IDLE with `rcnt` ← 0.
  - Simultaneous presses of step and load in the same cycle give `load` = 1 and `step` = 0.
  - Releasing load while step is still held does not generate a new step. Only a fresh `press[STEP_IDX]` starts a step.
  - `step` and `load` are never high in the same cycle.
- Buttons held through reset deassertion:
  - Sync flops start at 0, so a held button produces `press` 2+`DEB_TICKS` cycles after reset release.
  - That press is treated as a normal press.
- Reset asserted mid-repeat clears the FSM immediately. No `step` pulse is produced in the cycle `reset` is low.

Test Plan:
1. Reset low, `pb` = all ones, then release reset at edge 0 → `db` = all ones from edge 1+1+`DEB_TICKS` = edge 5; `press` = all ones for one cycle; `load` = 1 and `step` = 0 in that cycle.
2. `pb[5]` high for 2 cycles, then low (`DEB_TICKS` = 3) → `db[5]` stays 0; `press[5]` never asserts; `key_valid` stays 0.
3. `pb[0]` held 200 cycles → `step` high exactly in cycles P, P+50, P+60 … P+190. Release `pb[0]` → `release[0]` for one cycle, then no further `step`.
4. Hold `pb[0]`, then assert `pb[1]` at cycle P+30 → `load` pulses once and `step` stays 0. After `pb[1]` is released with `pb[0]` still held, no `step` until `pb[0]` is released and re-pressed.
5. `pb[7]` and `pb[3]` both stable high → `key_valid` = 1, `key_idx` = 3. Release `pb[3]` → `key_idx` = 7 on the cycle `db[3]` falls.
6. Pull `reset` low during REPEAT at P+55 → all outputs 0 asynchronously. After reset is released with `pb[0]` held, the first `step` is 5 cycles later and the repeat cadence restarts from that press.

Source files
------------

// File: rtl/pb_step_conditioner.sv
// Pushbutton front end: 2-flop sync, per-bit debounce, press/release strobes, priority encoder, step/load pulses.
// Latency: raw level to db is 1+DEB_TICKS clocks after first sample; strobes/step/load are combinational from db.
// Backpressure: none; strobes are single-cycle enables and are not held for a consumer.
module pb_step_conditioner #(
    parameter int NBTN          = 21,
    parameter int DEB_TICKS     = 3,
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_PERIOD = 10,
    parameter int STEP_IDX      = 0,
    parameter int LOAD_IDX      = 1
) (
    input  logic            i_hz100,
    input  logic            i_reset,
    input  logic [NBTN-1:0] i_pb,
    output logic [NBTN-1:0] o_db,
    output logic [NBTN-1:0] o_press,
    output logic [NBTN-1:0] o_release,
    output logic            o_key_valid,
    output logic [4:0]      o_key_idx,
    output logic            o_step,
    output logic            o_load
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic [NBTN-1:0] r_sync1;
    logic [NBTN-1:0] r_sync2;
    logic [NBTN-1:0] r_db;
    logic [NBTN-1:0] r_db_d;
    logic [3:0]      r_deb_cnt [NBTN];

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_rcnt;
    logic [15:0]     w_rcnt_nxt;
    logic            w_step;
    logic [NBTN-1:0] w_press;
    logic [NBTN-1:0] w_release;
    logic [4:0]      w_key_idx;

    // The counter only runs while the synchronized level disagrees with db,
    // so any disagreement shorter than DEB_TICKS clocks is forgotten.
    always_ff @(posedge i_hz100 or negedge i_reset) begin
        if (!i_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_d  <= '0;
            for (int i = 0; i < NBTN; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= i_pb;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            for (int i = 0; i < NBTN; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == 4'(DEB_TICKS - 1)) begin
                    r_db[i]      <= ~r_db[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 4'd1;
                end
            end
        end
    end

    assign w_press   = r_db & ~r_db_d;
    assign w_release = ~r_db & r_db_d;

    always_comb begin
        w_key_idx = '0;
        for (int i = NBTN - 1; i >= 0; i--) begin
            if (r_db[i]) begin
                w_key_idx = 5'(i);
            end
        end
    end

    always_ff @(posedge i_hz100 or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            r_rcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rcnt  <= w_rcnt_nxt;
        end
    end

    // A held load button parks the FSM in IDLE; only a fresh step press re-arms it.
    always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        w_step      = 1'b0;
        if (r_db[LOAD_IDX]) begin
            w_state_nxt = ST_IDLE;
            w_rcnt_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_press[STEP_IDX]) begin
                        w_step      = 1'b1;
                        w_rcnt_nxt  = 16'd1;
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!r_db[STEP_IDX]) begin
                        w_state_nxt = ST_IDLE;
                        w_rcnt_nxt  = '0;
                    end else if (r_rcnt == 16'(REPEAT_DELAY)) begin
                        w_step      = 1'b1;
                        w_rcnt_nxt  = 16'd1;
                        w_state_nxt = ST_REPEAT;
                    end else begin
                        w_rcnt_nxt  = r_rcnt + 16'd1;
                    end
                end
                ST_REPEAT: begin
                    if (!r_db[STEP_IDX]) begin
                        w_state_nxt = ST_IDLE;
                        w_rcnt_nxt  = '0;
                    end else if (r_rcnt == 16'(REPEAT_PERIOD)) begin
                        w_step      = 1'b1;
                        w_rcnt_nxt  = 16'd1;
                    end else begin
                        w_rcnt_nxt  = r_rcnt + 16'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_rcnt_nxt  = '0;
                end
            endcase
        end
    end

    assign o_db        = r_db;
    assign o_press     = w_press;
    assign o_release   = w_release;
    assign o_key_valid = |r_db;
    assign o_key_idx   = w_key_idx;
    assign o_step      = w_step;
    assign o_load      = w_press[LOAD_IDX];

endmodule

// File: tb/tb_pb_step_conditioner.sv
// Directed bench for pb_step_conditioner: debounce timing, strobes, encoder, auto-repeat, load priority, reset.
module tb_pb_step_conditioner;

    localparam int NBTN = 21;

    logic            clk;
    logic            rst_n;
    logic [NBTN-1:0] pb;
    logic [NBTN-1:0] db;
    logic [NBTN-1:0] press;
    logic [NBTN-1:0] rel;
    logic            key_valid;
    logic [4:0]      key_idx;
    logic            step;
    logic            load;

    int checks = 0;
    int errors = 0;

    pb_step_conditioner #(
        .NBTN(NBTN), .DEB_TICKS(3), .REPEAT_DELAY(50), .REPEAT_PERIOD(10),
        .STEP_IDX(0), .LOAD_IDX(1)
    ) dut (
        .i_hz100    (clk),
        .i_reset    (rst_n),
        .i_pb       (pb),
        .o_db       (db),
        .o_press    (press),
        .o_release  (rel),
        .o_key_valid(key_valid),
        .o_key_idx  (key_idx),
        .o_step     (step),
        .o_load     (load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [NBTN-1:0] ones;
        ones  = '1;
        rst_n = 1'b0;
        pb    = '1;
        repeat (3) tick();
        checks++; if (db !== '0) begin errors++; $display("FAIL rst_db got %h exp 0", db); end
        checks++; if (press !== '0 || rel !== '0) begin errors++; $display("FAIL rst_strobes press %h rel %h exp 0", press, rel); end
        checks++; if (step !== 1'b0 || load !== 1'b0) begin errors++; $display("FAIL rst_step_load step %b load %b exp 0", step, load); end
        checks++; if (key_valid !== 1'b0 || key_idx !== 5'd0) begin errors++; $display("FAIL rst_key valid %b idx %0d exp 0/0", key_valid, key_idx); end
        rst_n = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            tick();
            if (n == 4) begin
                checks++; if (db !== '0) begin errors++; $display("FAIL held_db_early got %h exp 0", db); end
            end
            if (n == 5) begin
                checks++; if (db !== ones) begin errors++; $display("FAIL held_db got %h exp %h", db, ones); end
                checks++; if (press !== ones) begin errors++; $display("FAIL held_press got %h exp %h", press, ones); end
                checks++; if (load !== 1'b1) begin errors++; $display("FAIL held_load got %b exp 1", load); end
                checks++; if (step !== 1'b0) begin errors++; $display("FAIL held_step got %b exp 0", step); end
            end
            if (n == 6) begin
                checks++; if (press !== '0 || load !== 1'b0) begin errors++; $display("FAIL held_press_once press %h load %b exp 0", press, load); end
                checks++; if (key_valid !== 1'b1 || key_idx !== 5'd0) begin errors++; $display("FAIL held_key valid %b idx %0d exp 1/0", key_valid, key_idx); end
            end
        end
        pb = '0;
        repeat (12) tick();
        checks++; if (db !== '0) begin errors++; $display("FAIL clear_db got %h exp 0", db); end
    endtask

    task automatic test_glitch();
        int npress;
        pb[5] = 1'b1;
        tick();
        tick();
        pb[5] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (db[5] !== 1'b0 || press[5] !== 1'b0 || key_valid !== 1'b0) begin
                errors++;
                $display("FAIL glitch k=%0d db5 %b press5 %b kv %b exp 0", k, db[5], press[5], key_valid);
            end
        end
        npress = 0;
        pb[5] = 1'b1;
        repeat (3) tick();
        pb[5] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (press[5] === 1'b1) npress++;
        end
        checks++; if (npress != 1) begin errors++; $display("FAIL pulse3_press got %0d exp 1", npress); end
        repeat (6) tick();
    endtask

    task automatic test_auto_repeat();
        int  idx;
        logic exp_step;
        logic exp_rel;
        pb[0] = 1'b1;
        for (int k = 1; k <= 230; k++) begin
            tick();
            idx      = k - 5;
            exp_step = (idx >= 0 && idx <= 199) && (idx == 0 || (idx >= 50 && (idx - 50) % 10 == 0));
            exp_rel  = (idx == 200);
            checks++; if (step !== exp_step) begin errors++; $display("FAIL repeat_step k=%0d got %b exp %b", k, step, exp_step); end
            checks++; if (rel[0] !== exp_rel) begin errors++; $display("FAIL repeat_release k=%0d got %b exp %b", k, rel[0], exp_rel); end
            if (k == 5) begin
                checks++; if (press[0] !== 1'b1) begin errors++; $display("FAIL repeat_press got %b exp 1", press[0]); end
            end
            if (k == 200) pb[0] = 1'b0;
        end
    endtask

    task automatic test_load_priority();
        logic exp_step;
        logic exp_load;
        pb[0] = 1'b1;
        for (int k = 1; k <= 170; k++) begin
            tick();
            exp_step = (k == 5) || (k == 150);
            exp_load = (k == 35);
            checks++; if (step !== exp_step) begin errors++; $display("FAIL load_step k=%0d got %b exp %b", k, step, exp_step); end
            checks++; if (load !== exp_load) begin errors++; $display("FAIL load_pulse k=%0d got %b exp %b", k, load, exp_load); end
            if (k == 30)  pb[1] = 1'b1;
            if (k == 60)  pb[1] = 1'b0;
            if (k == 130) pb[0] = 1'b0;
            if (k == 145) pb[0] = 1'b1;
            if (k == 152) pb[0] = 1'b0;
        end
    endtask

    task automatic test_encoder();
        logic [NBTN-1:0] exp_db;
        exp_db    = '0;
        exp_db[7] = 1'b1;
        exp_db[3] = 1'b1;
        pb[7] = 1'b1;
        pb[3] = 1'b1;
        repeat (8) tick();
        checks++; if (db !== exp_db) begin errors++; $display("FAIL enc_db got %h exp %h", db, exp_db); end
        checks++; if (key_valid !== 1'b1 || key_idx !== 5'd3) begin errors++; $display("FAIL enc_two valid %b idx %0d exp 1/3", key_valid, key_idx); end
        pb[3] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 4) begin
                checks++; if (key_idx !== 5'd3) begin errors++; $display("FAIL enc_before idx %0d exp 3", key_idx); end
            end
            if (k == 5) begin
                checks++; if (key_idx !== 5'd7) begin errors++; $display("FAIL enc_after idx %0d exp 7", key_idx); end
                checks++; if (rel[3] !== 1'b1) begin errors++; $display("FAIL enc_release3 got %b exp 1", rel[3]); end
            end
            if (k == 6) begin
                checks++; if (rel[3] !== 1'b0) begin errors++; $display("FAIL enc_release3_once got %b exp 0", rel[3]); end
            end
        end
        pb = '0;
        repeat (8) tick();
        checks++; if (key_valid !== 1'b0 || key_idx !== 5'd0) begin errors++; $display("FAIL enc_none valid %b idx %0d exp 0/0", key_valid, key_idx); end
    endtask

    task automatic test_reset_mid_repeat();
        logic exp_step;
        pb[0] = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (k == 55) begin
                checks++; if (step !== 1'b1) begin errors++; $display("FAIL mid_first_repeat got %b exp 1", step); end
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (db !== '0 || press !== '0 || rel !== '0) begin errors++; $display("FAIL async_clear db %h press %h rel %h exp 0", db, press, rel); end
        checks++; if (step !== 1'b0 || load !== 1'b0 || key_valid !== 1'b0 || key_idx !== 5'd0) begin
            errors++; $display("FAIL async_ctl step %b load %b kv %b idx %0d exp 0", step, load, key_valid, key_idx);
        end
        tick();
        tick();
        checks++; if (step !== 1'b0 || db !== '0) begin errors++; $display("FAIL in_reset step %b db %h exp 0", step, db); end
        rst_n = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            tick();
            exp_step = (n == 5) || (n == 55) || (n == 65);
            checks++; if (step !== exp_step) begin errors++; $display("FAIL post_reset_step n=%0d got %b exp %b", n, step, exp_step); end
        end
        pb = '0;
        repeat (10) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        pb    = '0;
        test_reset();
        test_glitch();
        test_auto_repeat();
        test_load_priority();
        test_encoder();
        test_reset_mid_repeat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
